// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one word-wide SRAM between the picorv32 native memory
// port (core) and a host loader/debug port. Round-robin between the two requesters;
// partial-strobe writes become read-modify-write so the SRAM only sees full words.
//
// state    | meaning
// IDLE     | sample requesters, grant, latch request
// RD       | SRAM read strobe for a plain read
// RD_WAIT  | SRAM data valid, capture into owner's rdata register
// RMW_RD   | SRAM read strobe for a partial write
// RMW_WAIT | SRAM data valid, merge strobed bytes over it
// WR       | SRAM full-word write strobe
// RESP     | one-cycle ready/ack to the owner
module sram_bus_arbiter #(
  parameter int DEPTH         = 1024,
  parameter bit RST_PRIO_CORE = 1'b1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_en,
  input  logic          c_valid,
  output logic          c_ready,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [3:0]    c_wstrb,
  output logic [31:0]   c_rdata,
  input  logic          h_req,
  input  logic [AW-1:0] h_addr,
  input  logic [31:0]   h_wdata,
  input  logic [3:0]    h_wstrb,
  output logic          h_ack,
  output logic [31:0]   h_rdata,
  output logic          err_oor,
  output logic          sram_rd_en,
  output logic          sram_wr_en,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic [31:0]   sram_mask,
  input  logic [31:0]   sram_rdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RMW_RD   = 3'd3;
  localparam logic [2:0] S_RMW_WAIT = 3'd4;
  localparam logic [2:0] S_WR       = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          own_core_q, own_core_d;
  logic          last_host_q, last_host_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   c_rdata_q, c_rdata_d;
  logic [31:0]   h_rdata_q, h_rdata_d;
  logic          err_q, err_d;

  logic core_elig;
  logic grant_core;
  logic c_oor;
  logic unused_addr_bits;

  assign core_elig  = c_valid & core_en;
  // Core wins when it is the only requester, or when both request and host went last.
  assign grant_core = core_elig & (~h_req | last_host_q);
  assign c_oor      = (c_addr >> (AW + 2)) != 32'd0;
  assign unused_addr_bits = ^c_addr[1:0];

  // Next-state, request latching, read capture and byte merge.
  always_comb begin
    state_d     = state_q;
    own_core_d  = own_core_q;
    last_host_d = last_host_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    c_rdata_d   = c_rdata_q;
    h_rdata_d   = h_rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (core_elig || h_req) begin
          own_core_d  = grant_core;
          last_host_d = ~grant_core;
          if (grant_core) begin
            addr_d  = c_addr[AW+1:2];
            wdata_d = c_wdata;
            wstrb_d = c_wstrb;
          end else begin
            addr_d  = h_addr;
            wdata_d = h_wdata;
            wstrb_d = h_wstrb;
          end
          if (grant_core && c_oor) begin
            // Out-of-range core access never reaches the SRAM; reads return zero.
            err_d   = 1'b1;
            state_d = S_RESP;
            if (c_wstrb == 4'h0) c_rdata_d = 32'd0;
          end else if (wstrb_d == 4'h0) begin
            state_d = S_RD;
          end else if (wstrb_d == 4'hF) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD:     state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (own_core_q) c_rdata_d = sram_rdata;
        else            h_rdata_d = sram_rdata;
        state_d = S_RESP;
      end
      S_RMW_RD: state_d = S_RMW_WAIT;
      S_RMW_WAIT: begin
        // Merge result replaces the latched word so WR always drives wdata_q.
        for (int i = 0; i < 4; i++) begin
          wdata_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : sram_rdata[8*i +: 8];
        end
        state_d = S_WR;
      end
      S_WR:     state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_core_q  <= 1'b0;
      last_host_q <= RST_PRIO_CORE;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'h0;
      c_rdata_q   <= 32'd0;
      h_rdata_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_core_q  <= own_core_d;
      last_host_q <= last_host_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      c_rdata_q   <= c_rdata_d;
      h_rdata_q   <= h_rdata_d;
      err_q       <= err_d;
    end
  end

  assign sram_rd_en = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign sram_wr_en = (state_q == S_WR);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_mask  = 32'hFFFF_FFFF;
  assign c_ready    = (state_q == S_RESP) &&  own_core_q;
  assign h_ack      = (state_q == S_RESP) && !own_core_q;
  assign c_rdata    = c_rdata_q;
  assign h_rdata    = h_rdata_q;
  assign err_oor    = err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: behavioural SRAM, per-feature scenario tasks and
// a randomized run checked against a word-array memory model.
module tb_sram_bus_arbiter;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 0, rst = 1, core_en = 1;
  logic          c_valid = 0, c_ready;
  logic [31:0]   c_addr = 0, c_wdata = 0, c_rdata;
  logic [3:0]    c_wstrb = 0;
  logic          h_req = 0, h_ack;
  logic [AW-1:0] h_addr = 0;
  logic [31:0]   h_wdata = 0, h_rdata;
  logic [3:0]    h_wstrb = 0;
  logic          err_oor, sram_rd_en, sram_wr_en;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_mask, sram_rdata = 0;

  int n_checks = 0, n_fail = 0;

  // Behavioural SRAM plus preload port and strobe monitors.
  logic [31:0]   mem [0:DEPTH-1];
  logic          pre_en = 0;
  logic [AW-1:0] pre_addr = 0;
  logic [31:0]   pre_data = 0;
  int            rd_cnt = 0, wr_cnt = 0, cr_cnt = 0;
  logic [31:0]   last_wr = 0;

  // Reference memory: what every word should hold after the transactions so far.
  logic [31:0]   mdl [0:DEPTH-1];

  sram_bus_arbiter #(.DEPTH(DEPTH), .RST_PRIO_CORE(1'b1)) dut (
    .clk(clk), .rst(rst), .core_en(core_en),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_wstrb(c_wstrb), .c_rdata(c_rdata),
    .h_req(h_req), .h_addr(h_addr), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
    .h_ack(h_ack), .h_rdata(h_rdata), .err_oor(err_oor),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_mask(sram_mask), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (sram_wr_en) mem[sram_addr] <= sram_wdata & sram_mask;
    if (sram_rd_en) sram_rdata <= mem[sram_addr];
    if (sram_rd_en) rd_cnt <= rd_cnt + 1;
    if (sram_wr_en) begin wr_cnt <= wr_cnt + 1; last_wr <= sram_wdata; end
    if (c_ready) cr_cnt <= cr_cnt + 1;
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1; pre_addr = AW'(a); pre_data = d;
    @(negedge clk);
    pre_en = 0;
    mdl[a] = d;
  endtask

  // Issue one request (core: byte address, host: word address) from an idle DUT.
  // lat = cycle index of ready/ack counted from the sampling cycle, -1 on timeout.
  task automatic txn(input bit is_core, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output int lat);
    @(negedge clk);
    if (is_core) begin c_valid = 1; c_addr = addr; c_wdata = wd; c_wstrb = ws; end
    else begin h_req = 1; h_addr = addr[AW-1:0]; h_wdata = wd; h_wstrb = ws; end
    lat = -1; rd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (is_core ? c_ready : h_ack) begin
        lat = i; rd = is_core ? c_rdata : h_rdata;
        break;
      end
    end
    if (is_core) c_valid = 0; else h_req = 0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if ({c_ready, h_ack, err_oor, sram_rd_en, sram_wr_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000", {c_ready, h_ack, err_oor, sram_rd_en, sram_wr_en}); end
    n_checks++; if ({c_rdata, h_rdata, sram_wdata} !== 96'd0 || sram_addr !== '0) begin
      n_fail++; $display("FAIL reset_data got c=%h h=%h w=%h a=%h exp 0", c_rdata, h_rdata, sram_wdata, sram_addr); end
    n_checks++; if (sram_mask !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sram_mask got=%h exp=ffffffff", sram_mask); end
  endtask

  task automatic test_arbitration;
    bit order [4];
    bit exp_core, last_host;
    bit rearm_c, rearm_h;
    int served;
    @(negedge clk);
    c_valid = 1; c_addr = 32'h40; c_wstrb = 0; h_req = 1; h_addr = 3; h_wstrb = 0;
    rearm_c = 0; rearm_h = 0; served = 0;
    for (int cyc = 0; cyc < 100 && served < 4; cyc++) begin
      @(negedge clk);
      if (rearm_c) begin c_valid = 1; rearm_c = 0; end
      if (rearm_h) begin h_req = 1; rearm_h = 0; end
      if (c_ready) begin order[served] = 1; served++; c_valid = 0; rearm_c = 1; end
      else if (h_ack) begin order[served] = 0; served++; h_req = 0; rearm_h = 1; end
    end
    c_valid = 0; h_req = 0;
    n_checks++; if (served !== 4) begin
      n_fail++; $display("FAIL arb_served got=%0d exp=4", served); end
    last_host = 1;
    for (int k = 0; k < served; k++) begin
      exp_core = last_host;  // both always requesting: alternate away from last grant
      n_checks++; if (order[k] !== exp_core) begin
        n_fail++; $display("FAIL arb_order[%0d] got_core=%0d exp_core=%0d", k, order[k], exp_core); end
      last_host = !exp_core;
    end
  endtask

  task automatic test_host_wr_rd;
    logic [31:0] rd; int lat;
    txn(0, 5, 32'h11223344, 4'hF, rd, lat);
    mdl[5] = 32'h11223344;
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL host_wr_lat got=%0d exp=2", lat); end
    txn(0, 5, 0, 4'h0, rd, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL host_rd_lat got=%0d exp=3", lat); end
    n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL host_rd_data got=%h exp=11223344", rd); end
  endtask

  task automatic test_rmw;
    logic [31:0] rd; int lat, r0, w0;
    preload(7, 32'hAABBCCDD);
    r0 = rd_cnt; w0 = wr_cnt;
    txn(1, 32'h1C, 32'h00005500, 4'b0010, rd, lat);
    mdl[7] = 32'hAABB55DD;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rmw_lat got=%0d exp=4", lat); end
    n_checks++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL rmw_strobes got rd=%0d wr=%0d exp 1/1", rd_cnt - r0, wr_cnt - w0); end
    n_checks++; if (last_wr !== 32'hAABB55DD) begin n_fail++; $display("FAIL rmw_wdata got=%h exp=aabb55dd", last_wr); end
    txn(1, 32'h1C, 0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'hAABB55DD) begin n_fail++; $display("FAIL rmw_readback got=%h exp=aabb55dd", rd); end
  endtask

  task automatic test_core_disable;
    logic [31:0] rd; int lat, cycles, cr0, idx; bit got;
    @(negedge clk);
    core_en = 0; c_valid = 1; c_addr = 32'h1C; c_wstrb = 0;
    cr0 = cr_cnt; cycles = 0;
    while (cycles < 20) begin
      idx = $urandom_range(0, 15);
      txn(0, 32'(idx), 0, 4'h0, rd, lat);
      n_checks++; if (lat !== 3 || rd !== mdl[idx]) begin
        n_fail++; $display("FAIL dis_host_rd lat=%0d data=%h exp lat=3 data=%h", lat, rd, mdl[idx]); end
      cycles += (lat < 0 ? 20 : lat + 1);
    end
    n_checks++; if (cr_cnt !== cr0) begin n_fail++; $display("FAIL dis_core_ready got=%0d pulses exp=0", cr_cnt - cr0); end
    @(negedge clk);
    core_en = 1; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (c_ready) begin got = 1; rd = c_rdata; end
    end
    c_valid = 0;
    n_checks++; if (!got || rd !== mdl[7]) begin
      n_fail++; $display("FAIL dis_core_served got=%0d data=%h exp 1 data=%h", got, rd, mdl[7]); end
  endtask

  task automatic test_oor;
    logic [31:0] rd, d; int lat, r0, w0;
    txn(1, 32'h1C, 0, 4'h0, rd, lat);   // leave a nonzero value in c_rdata
    r0 = rd_cnt; w0 = wr_cnt;
    txn(1, 32'h1000, 0, 4'h0, rd, lat);
    n_checks++; if (lat !== 1 || rd !== 0) begin
      n_fail++; $display("FAIL oor_rd got lat=%0d data=%h exp lat=1 data=0", lat, rd); end
    n_checks++; if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", err_oor); end
    txn(1, 32'h8000_0000, 32'hDEADBEEF, 4'hF, rd, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL oor_wr_lat got=%0d exp=1", lat); end
    n_checks++; if (rd_cnt !== r0 || wr_cnt !== w0) begin
      n_fail++; $display("FAIL oor_strobes got rd=%0d wr=%0d exp 0/0", rd_cnt - r0, wr_cnt - w0); end
    d = $urandom;
    txn(1, 32'hFFC, d, 4'hF, rd, lat);
    mdl[DEPTH-1] = d;
    txn(1, 32'hFFF, 0, 4'h0, rd, lat);
    n_checks++; if (lat !== 3 || rd !== d) begin
      n_fail++; $display("FAIL oor_last_word got lat=%0d data=%h exp lat=3 data=%h", lat, rd, d); end
    n_checks++; if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_sticky got=%b exp=1", err_oor); end
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, exp_c, exp_h; logic [3:0] ws;
    int lat, idx, r0, w0, exp_lat; bit is_core, seen_c, seen_h;
    seen_c = 0; seen_h = 0; exp_c = 0; exp_h = 0;
    for (int n = 0; n < 60; n++) begin
      is_core = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0: ws = 4'h0;
        1: ws = 4'hF;
        default: ws = 4'($urandom_range(1, 14));
      endcase
      wd = $urandom;
      r0 = rd_cnt; w0 = wr_cnt;
      txn(is_core, is_core ? 32'(idx * 4 + $urandom_range(0, 3)) : 32'(idx), wd, ws, rd, lat);
      exp_lat = (ws == 4'h0) ? 3 : (ws == 4'hF) ? 2 : 4;
      n_checks++; if (lat !== exp_lat) begin
        n_fail++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d ws=%h", n, lat, exp_lat, ws); end
      n_checks++; if (rd_cnt - r0 !== (ws != 4'hF ? 1 : 0) || wr_cnt - w0 !== (ws != 4'h0 ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd_strobes[%0d] got rd=%0d wr=%0d ws=%h", n, rd_cnt - r0, wr_cnt - w0, ws); end
      if (ws == 4'h0) begin
        n_checks++; if (rd !== mdl[idx]) begin
          n_fail++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rd, mdl[idx]); end
        if (is_core) begin exp_c = mdl[idx]; seen_c = 1; end
        else begin exp_h = mdl[idx]; seen_h = 1; end
      end else begin
        for (int b = 0; b < 4; b++) if (ws[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end
      if (is_core && seen_h) begin
        n_checks++; if (h_rdata !== exp_h) begin n_fail++; $display("FAIL rnd_h_hold[%0d] got=%h exp=%h", n, h_rdata, exp_h); end
      end
      if (!is_core && seen_c) begin
        n_checks++; if (c_rdata !== exp_c) begin n_fail++; $display("FAIL rnd_c_hold[%0d] got=%h exp=%h", n, c_rdata, exp_c); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat, w0, cr0;
    @(negedge clk);
    c_valid = 1; c_addr = 32'h24; c_wdata = $urandom; c_wstrb = 4'b0101;
    @(negedge clk);   // RMW_RD
    n_checks++; if (sram_rd_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rd_en got=%b exp=1", sram_rd_en); end
    @(negedge clk);   // RMW_WAIT
    w0 = wr_cnt; cr0 = cr_cnt;
    rst = 1; c_valid = 0;
    #1;
    n_checks++; if ({c_ready, h_ack, err_oor, sram_rd_en, sram_wr_en} !== 5'b0 ||
                    {c_rdata, h_rdata, sram_wdata} !== 96'd0 || sram_addr !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs flags=%b c=%h h=%h w=%h a=%h exp all 0",
                         {c_ready, h_ack, err_oor, sram_rd_en, sram_wr_en}, c_rdata, h_rdata, sram_wdata, sram_addr); end
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_cnt !== w0 || cr_cnt !== cr0) begin
      n_fail++; $display("FAIL rst_mid_no_write got wr=%0d ready=%0d exp 0/0", wr_cnt - w0, cr_cnt - cr0); end
    n_checks++; if (mem[9] !== mdl[9]) begin n_fail++; $display("FAIL rst_mid_mem got=%h exp=%h", mem[9], mdl[9]); end
    txn(0, 9, 0, 4'h0, rd, lat);
    n_checks++; if (lat !== 3 || rd !== mdl[9]) begin
      n_fail++; $display("FAIL rst_mid_readback got lat=%0d data=%h exp lat=3 data=%h", lat, rd, mdl[9]); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      pre_en = 1; pre_addr = AW'(i); pre_data = 0; mdl[i] = 0;
    end
    @(negedge clk);
    pre_en = 0;
    test_reset;
    @(negedge clk);
    rst = 0;
    test_arbitration;
    test_host_wr_rd;
    test_rmw;
    test_core_disable;
    test_oor;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
